// File: rtl/sr_debounce_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : sr_debounce_ctrl_if
// Purpose  : Button-side and latch-side signal bundle for sr_debounce_ctrl.
//            The master drives the raw buttons and observes the clean outputs;
//            the slave is the debounce controller itself.
// Revision : 1.0 - initial release
// ============================================================================
interface sr_debounce_ctrl_if;

  logic set_raw;      // raw set button, asynchronous, may bounce
  logic reset_raw;    // raw reset button, asynchronous, may bounce
  logic set_pulse;    // one-cycle pulse on an accepted set press
  logic reset_pulse;  // one-cycle pulse on an accepted reset press
  logic q;            // registered latch state
  logic qbar;         // registered complement of q
  logic conflict;     // both debounced levels high

  modport master (
    output set_raw,
    output reset_raw,
    input  set_pulse,
    input  reset_pulse,
    input  q,
    input  qbar,
    input  conflict
  );

  modport slave (
    input  set_raw,
    input  reset_raw,
    output set_pulse,
    output reset_pulse,
    output q,
    output qbar,
    output conflict
  );

endinterface
`default_nettype wire

// File: rtl/sr_debounce_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : sr_debounce_ctrl
// Purpose  : Synchronizes and debounces raw set/reset buttons, then drives
//            clean one-cycle pulses and a registered q/qbar pair that never
//            sees S=R=1. Simultaneous presses are flagged on conflict.
// Revision : 1.0 - initial release
// ============================================================================
module sr_debounce_ctrl #(
  parameter int DB_CYCLES = 4,
  parameter int CNT_W     = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  sr_debounce_ctrl_if.slave sr_if
);

  // Count value at which a persistent difference is accepted.
  localparam logic [CNT_W-1:0] c_DB_LAST = CNT_W'(DB_CYCLES - 1);

  // Channel 0 is set, channel 1 is reset.
  logic [1:0] w_raw;
  logic [1:0] s1_q;
  logic [1:0] s2_q;
  logic [1:0] w_db_q;
  logic [1:0] w_db_d;

  logic       w_set_rise;
  logic       w_reset_rise;
  logic       w_set_acc;
  logic       w_reset_acc;
  logic       q_d;

  logic       set_pulse_q;
  logic       reset_pulse_q;
  logic       q_q;
  logic       qbar_q;
  logic       conflict_q;

  assign w_raw = {sr_if.reset_raw, sr_if.set_raw};

  // Two-flop synchronizer on both raw buttons.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q <= 2'b00;
      s2_q <= 2'b00;
    end else begin
      s1_q <= w_raw;
      s2_q <= s1_q;
    end
  end

  generate
    for (genvar g = 0; g < 2; g++) begin : g_chan
      logic             db_q;
      logic             db_d;
      logic [CNT_W-1:0] cnt_q;
      logic [CNT_W-1:0] cnt_d;

      // Debounce next state: any matching cycle restarts the count, and a
      // difference lasting DB_CYCLES cycles loads the new level.
      always_comb begin
        db_d  = db_q;
        cnt_d = cnt_q;
        if (s2_q[g] == db_q) begin
          cnt_d = '0;
        end else if (cnt_q == c_DB_LAST) begin
          db_d  = s2_q[g];
          cnt_d = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      // Debounced level and counter registers.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          db_q  <= 1'b0;
          cnt_q <= '0;
        end else begin
          db_q  <= db_d;
          cnt_q <= cnt_d;
        end
      end

      assign w_db_q[g] = db_q;
      assign w_db_d[g] = db_d;
    end
  endgenerate

  // A rise is accepted only if the other channel will not be high after
  // this edge; a suppressed rise is simply lost, never replayed later.
  assign w_set_rise   = w_db_d[0] & ~w_db_q[0];
  assign w_reset_rise = w_db_d[1] & ~w_db_q[1];
  assign w_set_acc    = w_set_rise   & ~w_db_d[1];
  assign w_reset_acc  = w_reset_rise & ~w_db_d[0];

  // Latch state next value: set wins over hold, reset over hold; the two
  // acceptances are mutually exclusive by construction.
  always_comb begin
    q_d = q_q;
    if (w_set_acc) begin
      q_d = 1'b1;
    end else if (w_reset_acc) begin
      q_d = 1'b0;
    end
  end

  // Output registers, updated on the same edge as the debounced levels.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      set_pulse_q   <= 1'b0;
      reset_pulse_q <= 1'b0;
      q_q           <= 1'b0;
      qbar_q        <= 1'b1;
      conflict_q    <= 1'b0;
    end else begin
      set_pulse_q   <= w_set_acc;
      reset_pulse_q <= w_reset_acc;
      q_q           <= q_d;
      qbar_q        <= ~q_d;
      conflict_q    <= w_db_d[0] & w_db_d[1];
    end
  end

  assign sr_if.set_pulse   = set_pulse_q;
  assign sr_if.reset_pulse = reset_pulse_q;
  assign sr_if.q           = q_q;
  assign sr_if.qbar        = qbar_q;
  assign sr_if.conflict    = conflict_q;

endmodule
`default_nettype wire

// File: doc/sr_debounce_ctrl.md
# sr_debounce_ctrl

Clocked front-end for the SR latch. Takes two raw, asynchronous, active-high pushbutton inputs (set, reset) and synchronizes and debounces each one. It then emits clean one-cycle set/reset pulses and a registered q/qbar pair that never enters the forbidden S=R=1 condition. The block feeds the latch's sbar/rbar inputs, or replaces the latch in synchronous logic, and flags simultaneous-press conflicts.

## Interface
- DB_CYCLES, 4: consecutive cycles a synchronized input must differ from its debounced level before that level updates. Legal range is 1 to 2^CNT_W-1.
- CNT_W, 8: debounce counter width.
- clk  input  1  single clock. All state updates on the rising edge.
- rst_n  input  1  reset, asynchronous, active-low. Release is synchronous to clk externally.
- set_raw  input  1  raw set button, asynchronous, may bounce.
- reset_raw  input  1  raw reset button, asynchronous, may bounce.
- set_pulse  output  1  one-cycle pulse on an accepted set press.
- reset_pulse  output  1  one-cycle pulse on an accepted reset press.
- q  output  1  registered latch state.
- qbar  output  1  registered complement of q.
- conflict  output  1  high while both debounced levels are 1.

## Operation
- Synchronizer: each raw input passes through two flops (s1, s2), both reset to 0. All logic below uses s2.
- Debounce, applied per channel:
  - Each channel has a level db and a counter cnt, both reset to 0.
  - If s2 == db: cnt <= 0.
  - Else if cnt == DB_CYCLES-1: db <= s2 and cnt <= 0.
  - Else: cnt <= cnt+1.
  - Any single cycle where s2 matches db restarts the count. Bounces shorter than DB_CYCLES cycles are therefore never accepted.
- Rise event: set_rise is true on the edge where db_set loads 0->1. reset_rise is defined the same way for the reset channel.
- Arbitration, evaluated on the next-state values of db_set and db_reset:
  - set accepted = set_rise and next db_reset == 0.
  - reset accepted = reset_rise and next db_set == 0.
  - If both channels rise on the same edge, neither is accepted.
  - A rise suppressed by arbitration is consumed. It does not fire later when the other channel releases.
- Outputs, all registered:
  - set_pulse <= set accepted.
  - reset_pulse <= reset accepted.
  - q <= 1 if set accepted, 0 if reset accepted, otherwise hold.
  - qbar <= the complement of the q next-state, so qbar == ~q at all times.
  - conflict <= next db_set & next db_reset.
- Falling edges of db (button releases) produce no pulse and leave q unchanged.

## Timing
- Reset values while rst_n = 0, applied immediately: q=0, qbar=1, set_pulse=0, reset_pulse=0, conflict=0. All s1, s2, db and cnt registers are 0.
- Latency: let raw go high before edge E0 and stay high. Then:
  - s2 = 1 after E1.
  - db, pulse and q update at edge E(1+DB_CYCLES).
  - With DB_CYCLES=4, the outputs change at E5.
  - Release has the same latency but affects db only.
- Each pulse is exactly one clk cycle wide. The minimum spacing between two same-channel pulses is 2*DB_CYCLES cycles (release debounce plus press debounce).
- q, the pulse and conflict change on the same edge as the db update that causes them. There is no extra pipeline stage.
- Counter wrap cannot occur, because cnt clears at DB_CYCLES-1.
- Reset asserted mid-count: counts are discarded and outputs return to their reset values at once. After release, an input still held high needs the full DB_CYCLES+2 edges again and then produces a fresh pulse.

## Test plan
1. Reset check: assert rst_n=0 with both raw inputs toggling. Required: q=0, qbar=1, set_pulse=0, reset_pulse=0, conflict=0 throughout.
2. Basic set then reset (DB_CYCLES=4):
   - Hold set_raw=1 from E0. Required: set_pulse=1 only in the cycle after E5; q=1, qbar=0 from E5.
   - Drop set_raw. Required: no pulse, q stays 1.
   - Press reset_raw. Required: one reset_pulse, q=0 at DB_CYCLES+2 edges after the press.
3. Glitch rejection: set_raw=1 for 3 cycles, then 0. Required: db_set never changes, set_pulse=0, q unchanged.
4. Bounce: set_raw toggles every 2 cycles for 12 cycles, then holds 1. Required: exactly one set_pulse, DB_CYCLES+2 edges after the final rise; q=1.
5. Simultaneous press: both raw inputs rise before the same edge. Required:
   - At E5: conflict=1, no pulses, q unchanged.
   - Release reset_raw. Required: conflict=0 after debounce, and still no set_pulse.
   - Press reset_raw alone while set_raw stays held. Required: conflict=1 and reset suppressed.
6. Reset mid-debounce: set_raw held and rst_n pulsed low at E3. Required: outputs at reset values immediately. After rst_n release with set_raw still high, set_pulse occurs DB_CYCLES+2 edges later.
